// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register-bank responder: NUM_REGS x 32-bit read/write registers
// with byte strobes, OKAY/SLVERR responses and a flat register export bus.
module axi4_lite_slave #(
    parameter int NUM_REGS = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [31:0]              awaddr_in,
    input  logic [2:0]               awprot_in,
    input  logic                     awvalid_in,
    output logic                     awready_out,
    input  logic [31:0]              wdata_in,
    input  logic [3:0]               wstrb_in,
    input  logic                     wvalid_in,
    output logic                     wready_out,
    output logic [1:0]               bresp_out,
    output logic                     bvalid_out,
    input  logic                     bready_in,
    input  logic [31:0]              araddr_in,
    input  logic [2:0]               arprot_in,
    input  logic                     arvalid_in,
    output logic                     arready_out,
    output logic [31:0]              rdata_out,
    output logic [1:0]               rresp_out,
    output logic                     rvalid_out,
    input  logic                     rready_in,
    output logic [32*NUM_REGS-1:0]   regs_out
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0]      regs [NUM_REGS];

    logic [0:0]       w_state;
    logic             aw_done;
    logic             w_done;
    logic [IDX_W-1:0] aw_idx;
    logic             aw_oor;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;

    logic [0:0]       r_state;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic [IDX_W-1:0] ar_idx;
    logic             ar_oor;

    logic             unused;

    assign unused = ^{awprot_in, arprot_in, awaddr_in[1:0], araddr_in[1:0]};

    assign aw_hs  = awvalid_in && awready_out;
    assign w_hs   = wvalid_in && wready_out;
    assign ar_hs  = arvalid_in && arready_out;
    assign commit = (w_state == W_IDLE) && aw_done && w_done;
    assign ar_idx = araddr_in[IDX_W+1:2];
    assign ar_oor = |araddr_in[31:IDX_W+2];

    // Write channel: AW and W are latched independently, committed one edge later
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            aw_idx      <= '0;
            aw_oor      <= 1'b0;
            w_data      <= '0;
            w_strb      <= '0;
            awready_out <= 1'b0;
            wready_out  <= 1'b0;
            bvalid_out  <= 1'b0;
            bresp_out   <= RESP_OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_done     <= 1'b1;
                        aw_idx      <= awaddr_in[IDX_W+1:2];
                        aw_oor      <= |awaddr_in[31:IDX_W+2];
                        awready_out <= 1'b0;
                    end else if (!aw_done) begin
                        awready_out <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done     <= 1'b1;
                        w_data     <= wdata_in;
                        w_strb     <= wstrb_in;
                        wready_out <= 1'b0;
                    end else if (!w_done) begin
                        wready_out <= 1'b1;
                    end
                    if (commit) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        bvalid_out <= 1'b1;
                        bresp_out  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready_in) begin
                        bvalid_out  <= 1'b0;
                        awready_out <= 1'b1;
                        wready_out  <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (commit && !aw_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled at the AR edge, so a same-edge commit is not visible
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            arready_out <= 1'b0;
            rvalid_out  <= 1'b0;
            rdata_out   <= '0;
            rresp_out   <= RESP_OKAY;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_out <= 1'b0;
                        rvalid_out  <= 1'b1;
                        rdata_out   <= ar_oor ? 32'h0 : regs[ar_idx];
                        rresp_out   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
                        r_state     <= R_DATA;
                    end else begin
                        arready_out <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready_in) begin
                        rvalid_out  <= 1'b0;
                        arready_out <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[32*k +: 32] = regs[k];
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Scoreboard bench for axi4_lite_slave: directed writes/reads, expected
// B/R responses queued at issue and checked by an independent monitor.
module tb_axi4_lite_slave;

    localparam int NR = 16;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [31:0]     awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [31:0]     araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b1;
    logic [32*NR-1:0] regs;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 aclk = ~aclk;

    axi4_lite_slave #(.NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr_in(awaddr), .awprot_in(awprot),
        .awvalid_in(awvalid), .awready_out(awready),
        .wdata_in(wdata), .wstrb_in(wstrb),
        .wvalid_in(wvalid), .wready_out(wready),
        .bresp_out(bresp), .bvalid_out(bvalid), .bready_in(bready),
        .araddr_in(araddr), .arprot_in(arprot),
        .arvalid_in(arvalid), .arready_out(arready),
        .rdata_out(rdata), .rresp_out(rresp),
        .rvalid_out(rvalid), .rready_in(rready),
        .regs_out(regs)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: consumes one expected entry per completed B/R handshake
    always @(negedge aclk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (aresetn && bvalid && bready) begin
            if (bq.size() == 0) begin
                chk("b_unexpected", 32'(bvalid), 32'h0);
            end else begin
                eb = bq.pop_front();
                chk("bresp", 32'(bresp), 32'(eb));
            end
        end
        if (aresetn && rvalid && rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected", 32'(rvalid), 32'h0);
            end else begin
                er = rq.pop_front();
                chk("rdata", rdata, er[31:0]);
                chk("rresp", 32'(rresp), 32'(er[33:32]));
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] eresp,
                            input int aw_dly, input int w_dly);
        bit aw_ok = 0;
        bit w_ok = 0;
        int c = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        bq.push_back(eresp);
        while (!(aw_ok && w_ok) && c < 50) begin
            awvalid = !aw_ok && (c >= aw_dly);
            wvalid = !w_ok && (c >= w_dly);
            @(negedge aclk);
            if (w_ok && !aw_ok) begin
                chk("wready_drop", 32'(wready), 32'h0);
                chk("awready_kept", 32'(awready), 32'h1);
            end
            if (aw_ok && !w_ok) begin
                chk("awready_drop", 32'(awready), 32'h0);
                chk("wready_kept", 32'(wready), 32'h1);
            end
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            @(posedge aclk);
            #1;
            c++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (!(aw_ok && w_ok)) chk("write_timeout", 32'h1, 32'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] eresp);
        bit ok = 0;
        int c = 0;
        araddr = a;
        rq.push_back({eresp, ed});
        arvalid = 1'b1;
        while (!ok && c < 50) begin
            @(negedge aclk);
            if (arready) ok = 1;
            @(posedge aclk);
            #1;
            c++;
        end
        arvalid = 1'b0;
        if (!ok) chk("read_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((bq.size() != 0 || rq.size() != 0) && c < 50) begin
            @(posedge aclk);
            #1;
            c++;
        end
        if (c >= 50) chk("idle_timeout", 32'h1, 32'h0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(awready), 32'h0);
        chk("rst_wready", 32'(wready), 32'h0);
        chk("rst_arready", 32'(arready), 32'h0);
        chk("rst_bvalid", 32'(bvalid), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_bresp", 32'(bresp), 32'h0);
        chk("rst_rresp", 32'(rresp), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        for (int k = 0; k < NR; k++) chk("rst_reg", regs[32*k +: 32], 32'h0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rel_awready", 32'(awready), 32'h1);
        chk("rel_wready", 32'(wready), 32'h1);
        chk("rel_arready", 32'(arready), 32'h1);

        // Full write / read
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
        wait_idle();
        chk("reg2_full", regs[95:64], 32'hDEADBEEF);
        do_read(32'h08, 32'hDEADBEEF, 2'b00);
        wait_idle();

        // Partial strobes and empty strobe
        do_write(32'h04, 32'h11223344, 4'hF, 2'b00, 0, 0);
        do_write(32'h04, 32'hAABBCCDD, 4'b0101, 2'b00, 0, 0);
        wait_idle();
        chk("reg1_partial", regs[63:32], 32'h11BB33DD);
        do_write(32'h07, 32'hFFFFFFFF, 4'h0, 2'b00, 0, 0);
        wait_idle();
        chk("reg1_nostrb", regs[63:32], 32'h11BB33DD);
        do_read(32'h06, 32'h11BB33DD, 2'b00);
        wait_idle();

        // Out of range
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0);
        wait_idle();
        chk("oor_reg0", regs[31:0], 32'h0);
        chk("oor_reg1", regs[63:32], 32'h11BB33DD);
        chk("oor_reg2", regs[95:64], 32'hDEADBEEF);
        chk("oor_reg15", regs[511:480], 32'h0);
        do_read(32'h40, 32'h0, 2'b10);
        wait_idle();

        // Channel ordering
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 2'b00, 3, 0);
        do_write(32'h14, 32'h0BADC0DE, 4'hF, 2'b00, 0, 2);
        wait_idle();
        chk("reg4_wfirst", regs[159:128], 32'hCAFEF00D);
        chk("reg5_awfirst", regs[191:160], 32'h0BADC0DE);
        do_read(32'h10, 32'hCAFEF00D, 2'b00);
        do_read(32'h14, 32'h0BADC0DE, 2'b00);
        wait_idle();

        // Same-edge commit and read of reg2 returns the old value
        fork
            do_write(32'h08, 32'h12345678, 4'hF, 2'b00, 0, 0);
            begin
                @(posedge aclk);
                #1;
                do_read(32'h08, 32'hDEADBEEF, 2'b00);
            end
        join
        wait_idle();
        chk("reg2_new", regs[95:64], 32'h12345678);

        // Back-pressure on both response channels
        bready = 1'b0;
        rready = 1'b0;
        do_write(32'h18, 32'h66666666, 4'hF, 2'b00, 0, 0);
        do_read(32'h10, 32'hCAFEF00D, 2'b00);
        @(posedge aclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_bvalid", 32'(bvalid), 32'h1);
            chk("stall_bresp", 32'(bresp), 32'h0);
            chk("stall_rvalid", 32'(rvalid), 32'h1);
            chk("stall_rdata", rdata, 32'hCAFEF00D);
        end
        @(posedge aclk);
        #1;
        bready = 1'b1;
        rready = 1'b1;
        wait_idle();
        chk("reg6", regs[223:192], 32'h66666666);

        // Reset during W_RESP
        bready = 1'b0;
        do_write(32'h1C, 32'h77777777, 4'hF, 2'b00, 0, 0);
        @(posedge aclk);
        #1;
        chk("pre_rst_bvalid", 32'(bvalid), 32'h1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", 32'(bvalid), 32'h0);
        chk("mid_rst_reg7", regs[255:224], 32'h0);
        chk("mid_rst_reg2", regs[95:64], 32'h0);
        bq.delete();
        bready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("post_rst_bvalid", 32'(bvalid), 32'h0);
        end
        chk("post_rst_awready", 32'(awready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
